muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers, in the
//  execute stage beside alu. Takes the same operand bus (num1, num2).
//  Runs MULT/MULTU/DIV/DIVU over multiple cycles and handles MTHI/MTLO in a
//  single cycle. hi/lo are forwarded back into alu operand select for MFHI/MFLO.
//  busy stalls the upstream ID/EX register.
// PARAMETERS
//  WIDTH  32  operand width; hi/lo are WIDTH each; iteration count = WIDTH
// PORTS
//  clk           in   1      rising-edge clock
//  reset_n       in   1      asynchronous, active-low reset
//  num1          in   WIDTH  rs operand (dividend / multiplicand / MT source)
//  num2          in   WIDTH  rt operand (divisor / multiplier)
//  op            in   3      `MD_NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO
//  start         in   1      op valid this cycle
//  flush         in   1      abort in-flight operation (exception)
//  busy          out  1      operation in progress; start ignored while high
//  done          out  1      one-cycle pulse when hi/lo updated by mul/div
//  div_by_zero   out  1      qualifies done: divisor was 0
//  hi            out  WIDTH  HI register
//  lo            out  WIDTH  LO register
//  op_invalid    out  1      comb: start && op not a defined encoding
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; busy=0; done=0; div_by_zero=0;
//   hi=lo=0. Clears any in-flight op. Outputs are valid in the first cycle
//   after deassertion.
//  FSM states: IDLE -> PREP -> RUN(x WIDTH) -> FIX -> IDLE.
//   IDLE: start && !busy && op in {MULT,MULTU,DIV,DIVU} -> PREP; latch op.
//    Signed ops latch |num1|, |num2| and the sign bits.
//   PREP: one cycle; clear accumulator; count=WIDTH-1.
//   RUN: one shift-add (mul) or restoring-subtract (div) step per cycle;
//    count==0 -> FIX.
//   FIX: apply signs; write hi/lo at the end of the cycle; done=1 next cycle.
//  busy is high from the cycle after the start edge through FIX.
//   mul/div: hi/lo new values are visible WIDTH+2 cycles after the start edge
//   (34 at default).
//  MTHI/MTLO with start in IDLE: hi or lo <= num1 at that edge; no busy; no
//   done pulse.
//  start while busy: ignored, no state change. Upstream holds its stall.
//  start with op=MD_NONE or an undefined code: no action; op_invalid=1 (comb).
//  Arithmetic:
//   MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product.
//   DIV/DIVU: lo = quotient truncated toward 0; hi = remainder, with the sign
//    of the dividend.
//   DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
//   Divisor 0: full latency still taken; hi=num1, lo=0xFFFFFFFF;
//    div_by_zero=1 with done.
//  flush: in IDLE, no effect. In PREP/RUN/FIX: next state IDLE, hi/lo
//   unchanged, no done. flush wins over a FIX-cycle write. A start in the same
//   cycle as flush is ignored.
// STRUCTURE
//  muldiv.h (shared with the alu.h set): `MD_* op encodings and
//  `MD_OP_WIDTH=3.
//  FSM state encodings are localparams inside the module.
//  No sub-module: one datapath with a {rem/prod_hi, quot/prod_lo} 2*WIDTH
//  shift register, shared by mul and div.
// TESTING
//  1 MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 34 cycles hi=0xFFFFFFFE,
//    lo=0x00000001, done pulse.
//  2 MULT 0xFFFFFFFE(-2)*0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  3 DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    DIVU 7/2 -> lo=3, hi=1.
//  4 DIVU 0x12345678/0 -> hi=0x12345678, lo=0xFFFFFFFF, div_by_zero=1.
//    DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  5 MULT started, flush at cycle 10 -> busy=0 next cycle, hi/lo keep the
//    values from test 4. start during busy ignored. MTHI 0xDEADBEEF -> hi
//    next cycle.
//  6 reset_n low mid-RUN -> immediately busy=0, hi=lo=0. No done after
//    release.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings match the execute-stage operand select decode.
package muldiv_unit_pkg;

   localparam int unsigned MD_OP_WIDTH = 3;

   typedef enum logic [MD_OP_WIDTH-1:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shared {hi, lo} shift register performs shift-add multiply or restoring divide.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [WIDTH-1:0]       num1,
   input  logic [WIDTH-1:0]       num2,
   input  logic [MD_OP_WIDTH-1:0] op,
   input  logic                   start,
   input  logic                   flush,
   output logic                   busy,
   output logic                   done,
   output logic                   div_by_zero,
   output logic [WIDTH-1:0]       hi,
   output logic [WIDTH-1:0]       lo,
   output logic                   op_invalid
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PREP = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_FIX  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic               is_div_q, is_div_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic               dbz_flag_q, dbz_flag_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;

   logic               start_ok, md_start, op_div, op_signed;
   logic [WIDTH-1:0]   abs1, abs2;
   logic [WIDTH:0]     mul_sum, div_shift;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_s;
   logic [WIDTH-1:0]   quot_s, rem_s;

   assign start_ok  = start && !flush && (state_q == ST_IDLE);
   assign md_start  = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   assign op_div    = (op == MD_DIV) || (op == MD_DIVU);
   assign op_signed = (op == MD_MULT) || (op == MD_DIV);
   assign abs1      = (op_signed && num1[WIDTH-1]) ? -num1 : num1;
   assign abs2      = (op_signed && num2[WIDTH-1]) ? -num2 : num2;

   // Multiply: add multiplicand on the low bit, shift the whole pair right.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
   assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                              : {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};

   // Divide: shift remainder left, subtract when it fits, quotient bit enters at the bottom.
   assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
   always_comb begin
      if (div_shift >= {1'b0, opb_q}) begin
         div_next = {div_shift[WIDTH-1:0] - opb_q, acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
   end

   assign prod_s = (sa_q ^ sb_q) ? -acc_q : acc_q;
   assign quot_s = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_s  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d    = state_q;
      is_div_d   = is_div_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      dbz_flag_d = dbz_flag_q;
      opb_d      = opb_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      dbz_d      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_ok && md_start) begin
               state_d    = ST_PREP;
               is_div_d   = op_div;
               sa_d       = op_signed && num1[WIDTH-1];
               sb_d       = op_signed && num2[WIDTH-1];
               dbz_flag_d = (num2 == '0);
               opb_d      = op_div ? abs2 : abs1;
               acc_d      = {{WIDTH{1'b0}}, (op_div ? abs1 : abs2)};
            end else if (start_ok && (op == MD_MTHI)) begin
               hi_d = num1;
            end else if (start_ok && (op == MD_MTLO)) begin
               lo_d = num1;
            end
         end
         ST_PREP: begin
            acc_d[2*WIDTH-1:WIDTH] = '0;
            cnt_d                  = CNT_LAST;
            state_d                = ST_RUN;
         end
         ST_RUN: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = ST_FIX;
         end
         ST_FIX: begin
            if (is_div_q) begin
               hi_d = rem_s;
               lo_d = dbz_flag_q ? '1 : quot_s;
            end else begin
               hi_d = prod_s[2*WIDTH-1:WIDTH];
               lo_d = prod_s[WIDTH-1:0];
            end
            done_d  = 1'b1;
            dbz_d   = is_div_q && dbz_flag_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Flush abandons the operation, including a pending FIX write.
      if (flush && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
         dbz_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         is_div_q   <= 1'b0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         dbz_flag_q <= 1'b0;
         opb_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_div_q   <= is_div_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         dbz_flag_q <= dbz_flag_d;
         opb_q      <= opb_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         dbz_q      <= dbz_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign op_invalid  = start && !((op >= MD_MULT) && (op <= MD_MTLO));

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of mul/div vectors plus flush, MT and reset sequences.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] num1, num2;
   logic [2:0]  op;
   logic        start, flush;
   logic        busy, done, div_by_zero, op_invalid;
   logic [31:0] hi, lo;

   int tests = 0;
   int fails = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .num1       (num1),
      .num2       (num2),
      .op         (op),
      .start      (start),
      .flush      (flush),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .hi         (hi),
      .lo         (lo),
      .op_invalid (op_invalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_dbz;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue a mul/div and return the edge count from the start edge to the done pulse.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
      bit seen;
      @(negedge clk);
      op = o; num1 = a; num2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = MD_NONE;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      lat  = -1;
      seen = 1'b0;
      for (int c = 1; c <= 60 && !seen; c++) begin
         @(posedge clk); #1;
         if (done) begin
            lat  = c;
            seen = 1'b1;
         end
      end
   endtask

   initial begin
      int lat;
      int donecnt;

      vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[1]  = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
      vecs[2]  = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
      vecs[3]  = '{MD_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0};
      vecs[4]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[5]  = '{MD_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
      vecs[6]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[7]  = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
      vecs[8]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[9]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[10] = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
      vecs[11] = '{MD_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
      vecs[12] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};

      reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = MD_NONE; num1 = '0; num2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_dbz",  {31'd0, div_by_zero}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d_latency", i), lat, 32'd34);
         check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
         check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
         check($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].exp_dbz});
         check($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
         @(posedge clk); #1;
         check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      end

      // Flush mid-run; a start issued while busy must be ignored.
      @(negedge clk); op = MD_MULT; num1 = 32'd3; num2 = 32'd5; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); op = MD_MTHI; num1 = 32'h11111111; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      check("busy_start_ignored_hi", hi, 32'h00000000);
      check("busy_still_high", {31'd0, busy}, 32'd1);
      repeat (4) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_hi", hi, 32'h00000000);
      check("flush_lo", lo, 32'h80000000);
      donecnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) donecnt++;
      end
      check("flush_no_done", donecnt, 32'd0);
      check("flush_hi_kept", hi, 32'h00000000);

      // MT moves are single-cycle; start together with flush is dropped.
      @(negedge clk); op = MD_MTHI; num1 = 32'hDEADBEEF; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      check("mthi_hi", hi, 32'hDEADBEEF);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      check("mthi_done", {31'd0, done}, 32'd0);
      @(negedge clk); op = MD_MTLO; num1 = 32'hCAFEF00D; start = 1'b1;
      #1 check("mtlo_valid_op", {31'd0, op_invalid}, 32'd0);
      @(posedge clk); #1; start = 1'b0;
      check("mtlo_lo", lo, 32'hCAFEF00D);
      @(negedge clk); op = MD_MTLO; num1 = 32'h55555555; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1; start = 1'b0; flush = 1'b0;
      check("flush_start_lo", lo, 32'hCAFEF00D);

      // Undefined and NONE ops flag op_invalid and do nothing.
      @(negedge clk); op = 3'd7; num1 = 32'h1; start = 1'b1;
      #1 check("inv_op7", {31'd0, op_invalid}, 32'd1);
      @(posedge clk); #1;
      check("inv_op7_busy", {31'd0, busy}, 32'd0);
      op = MD_NONE;
      #1 check("inv_none", {31'd0, op_invalid}, 32'd1);
      start = 1'b0; op = 3'd7;
      #1 check("inv_nostart", {31'd0, op_invalid}, 32'd0);
      check("inv_hi_kept", hi, 32'hDEADBEEF);
      check("inv_lo_kept", lo, 32'hCAFEF00D);

      // Asynchronous reset in the middle of RUN.
      @(negedge clk); op = MD_MULTU; num1 = 32'hFFFFFFFF; num2 = 32'hFFFFFFFF; start = 1'b1;
      @(posedge clk); #1; start = 1'b0; op = MD_NONE;
      repeat (15) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      @(negedge clk); reset_n = 1'b1;
      donecnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) donecnt++;
      end
      check("rst_no_done", donecnt, 32'd0);
      check("rst_hi_after", hi, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
